// File: rtl/de0_nano_cpu_cpu_ocimem_sched.sv
// de0_nano_cpu_cpu_ocimem_sched
//   Shares the single-port OCI monitor RAM between JTAG debug-slave command
//   strobes and the CPU-side Avalon debug_mem slave. It owns the JTAG address
//   and data registers (MonAReg / MonDReg) and the monitor_ready handshake.
//
//   Build option: define OCIMEM_WRITE_PROTECT_EN to silently discard Avalon
//   writes while the CPU is not in debug mode (debugack=0). JTAG writes are
//   never affected. Without the macro, debugack is ignored.
module de0_nano_cpu_cpu_ocimem_sched #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  // JTAG pending slot and bookkeeping
  logic              pend_valid_reg;
  logic              pend_write_reg;
  logic [DATA_W-1:0] pend_data_reg;
  logic              jtag_active_reg;
  logic              overrun_reg;
  logic [ADDR_W-1:0] mona_reg;
  logic [DATA_W-1:0] mond_reg;

  // Operation currently owned by the FSM
  logic              cur_jtag_reg;
  logic              cur_write_reg;
  logic              last_grant_jtag_reg;   // 0 = Avalon was granted last

  // RAM port and Avalon read data registers
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_wdata_reg;
  logic [3:0]        ram_be_reg;
  logic              ram_wren_reg;
  logic              ram_rden_reg;
  logic [DATA_W-1:0] readdata_reg;

  // Decoded JTAG intake
  logic jtag_busy;
  logic any_strobe;
  logic sel_a;
  logic sel_b;
  logic sel_n;
  logic lower_dropped;
  logic accept;
  logic queue_read;
  logic queue_write;
  logic drop;

  // FSM outputs
  logic avs_req;
  logic grant_jtag;
  logic grant_avs;
  logic grant_write;
  logic grant_wren_ok;
  logic jtag_done;
  logic capture_en;
  logic waitrequest_out;

  // Write-protect gate for Avalon writes
  logic avs_write_allowed;

`ifdef OCIMEM_WRITE_PROTECT_EN
  assign avs_write_allowed = debugack;
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};
`else
  assign avs_write_allowed = 1'b1;
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0], debugack};
`endif

  // Strobe priority a > b > no_action_a; the slot is occupied from acceptance
  // until the JTAG operation retires, so anything arriving then is dropped.
  always_comb begin
    jtag_busy     = pend_valid_reg | jtag_active_reg;
    any_strobe    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    sel_a         = take_action_ocimem_a;
    sel_b         = ~take_action_ocimem_a & take_action_ocimem_b;
    sel_n         = ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;
    lower_dropped = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                  | (take_action_ocimem_b & take_no_action_ocimem_a);
    accept        = any_strobe & ~jtag_busy;
    queue_read    = accept & ((sel_a & jdo[34]) | sel_n);
    queue_write   = accept & sel_b;
    drop          = (any_strobe & jtag_busy) | lower_dropped;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: reads go through CAPTURE, only Avalon ops take an ACK cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (grant_jtag || grant_avs) begin
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cur_write_reg) begin
          state_next = cur_jtag_reg ? S_IDLE : S_ACK;
        end else begin
          state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_next = cur_jtag_reg ? S_IDLE : S_ACK;
      end
      S_ACK: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM outputs: round-robin grant in IDLE, retire/capture strobes, waitrequest
  always_comb begin
    avs_req         = avs_read | avs_write;
    grant_jtag      = 1'b0;
    grant_avs       = 1'b0;
    if (state_reg == S_IDLE) begin
      grant_jtag = pend_valid_reg & (~avs_req | ~last_grant_jtag_reg);
      grant_avs  = avs_req & (~pend_valid_reg | last_grant_jtag_reg);
    end
    grant_write     = grant_jtag ? pend_write_reg : avs_write;
    grant_wren_ok   = grant_jtag | avs_write_allowed;
    jtag_done       = cur_jtag_reg & (((state_reg == S_ACCESS) & cur_write_reg)
                                     | (state_reg == S_CAPTURE));
    capture_en      = (state_reg == S_CAPTURE);
    waitrequest_out = avs_req & (state_reg != S_ACK);
  end

  // JTAG intake: pending slot, MonAReg pointer, overrun flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_reg  <= 1'b0;
      pend_write_reg  <= 1'b0;
      pend_data_reg   <= '0;
      jtag_active_reg <= 1'b0;
      overrun_reg     <= 1'b0;
      mona_reg        <= '0;
    end else begin
      if (grant_jtag) begin
        pend_valid_reg <= 1'b0;
      end else if (queue_read || queue_write) begin
        pend_valid_reg <= 1'b1;
        pend_write_reg <= queue_write;
      end
      if (queue_write) begin
        pend_data_reg <= jdo[34:3];
      end

      if (grant_jtag) begin
        jtag_active_reg <= 1'b1;
      end else if (jtag_done) begin
        jtag_active_reg <= 1'b0;
      end

      // A new drop this cycle wins over the clear from an accepted 'a'
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (accept && sel_a) begin
        overrun_reg <= 1'b0;
      end

      // Load and increment never coincide: loads need an idle slot
      if (accept && sel_a) begin
        mona_reg <= jdo[17 +: ADDR_W];
      end else if (jtag_done) begin
        mona_reg <= mona_reg + ADDR_W'(1);
      end
    end
  end

  // RAM port registers: latched on grant, strobes pulse for the ACCESS cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_reg        <= '0;
      ram_wdata_reg       <= '0;
      ram_be_reg          <= '0;
      ram_wren_reg        <= 1'b0;
      ram_rden_reg        <= 1'b0;
      cur_jtag_reg        <= 1'b0;
      cur_write_reg       <= 1'b0;
      last_grant_jtag_reg <= 1'b0;
    end else begin
      ram_wren_reg <= 1'b0;
      ram_rden_reg <= 1'b0;
      if (grant_jtag || grant_avs) begin
        ram_addr_reg        <= grant_jtag ? mona_reg : avs_address;
        ram_wdata_reg       <= grant_jtag ? pend_data_reg : avs_writedata;
        ram_be_reg          <= grant_jtag ? 4'hF : avs_byteenable;
        ram_wren_reg        <= grant_write & grant_wren_ok;
        ram_rden_reg        <= ~grant_write;
        cur_jtag_reg        <= grant_jtag;
        cur_write_reg       <= grant_write;
        last_grant_jtag_reg <= grant_jtag;
      end
    end
  end

  // Read capture: RAM data goes to MonDReg for JTAG, avs_readdata for Avalon
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mond_reg     <= '0;
      readdata_reg <= '0;
    end else if (capture_en) begin
      if (cur_jtag_reg) begin
        mond_reg <= ram_q;
      end else begin
        readdata_reg <= ram_q;
      end
    end
  end

  assign avs_readdata    = readdata_reg;
  assign avs_waitrequest = waitrequest_out;
  assign ram_addr        = ram_addr_reg;
  assign ram_wdata       = ram_wdata_reg;
  assign ram_be          = ram_be_reg;
  assign ram_wren        = ram_wren_reg;
  assign ram_rden        = ram_rden_reg;
  assign MonAReg         = mona_reg;
  assign MonDReg         = mond_reg;
  assign monitor_ready   = ~jtag_busy;
  assign jtag_overrun    = overrun_reg;

endmodule

// File: tb/tb_de0_nano_cpu_cpu_ocimem_sched.sv
// Testbench for de0_nano_cpu_cpu_ocimem_sched: behavioural single-port RAM,
// table-driven Avalon/JTAG transactions plus hand-timed corner sequences.
module tb_de0_nano_cpu_cpu_ocimem_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic        debugack;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_wren;
  logic        ram_rden;
  logic [31:0] ram_q;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_overrun;

  int checks = 0;
  int failures = 0;

  // Bench-side RAM model with a preload port used during reset
  logic [31:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  always #5 clk = ~clk;

  de0_nano_cpu_cpu_ocimem_sched dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .debugack                (debugack),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_be                  (ram_be),
    .ram_wren                (ram_wren),
    .ram_rden                (ram_rden),
    .ram_q                   (ram_q),
    .MonAReg                 (MonAReg),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
  );

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  typedef struct {
    bit          jtag;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // kind: 0 = take_action_ocimem_a, 1 = take_action_ocimem_b, 2 = take_no_action_ocimem_a
  task automatic jtag_strobe(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_action_ocimem_b    = (kind == 1);
    take_no_action_ocimem_a = (kind == 2);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!monitor_ready && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'h0, monitor_ready}, 32'h1);
  endtask

  task automatic avs_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output logic [31:0] rdata, output int waits);
    avs_address    = addr;
    avs_writedata  = data;
    avs_byteenable = be;
    avs_read       = !wr;
    avs_write      = wr;
    waits = 0;
    #1;
    while (avs_waitrequest && waits < 20) begin
      tick();
      #1;
      waits++;
    end
    rdata = avs_readdata;
    tick();
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          waits;
    logic [7:0]  nxt;
    int acks, jdone, jacc, run, max_run, bad;
    logic prev_ready;

    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    debugack = 1'b1;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = 4'hF;
    pre_en = 1'b1;

    // Preload RAM while in reset: mem[i] = i, with a few marked locations
    for (int i = 0; i < 256; i++) begin
      pre_addr = 8'(i);
      pre_data = 32'(i);
      if (i == 8'h10) pre_data = 32'hDEADBEEF;
      if (i == 8'h20) pre_data = 32'h12345678;
      tick();
    end
    pre_en = 1'b0;

    // Reset state
    check("rst_MonAReg", {24'h0, MonAReg}, 32'h0);
    check("rst_MonDReg", MonDReg, 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_ram_addr", {24'h0, ram_addr}, 32'h0);
    check("rst_ram_strobes", {30'h0, ram_wren, ram_rden}, 32'h0);
    check("rst_monitor_ready", {31'h0, monitor_ready}, 32'h1);
    check("rst_overrun", {31'h0, jtag_overrun}, 32'h0);
    check("rst_waitrequest", {31'h0, avs_waitrequest}, 32'h0);
    reset_n = 1'b1;
    tick();

    // JTAG read of 0x10: strobe in cycle S, request in IDLE at S+1, data at S+4
    jtag_strobe(0, jdo_addr(8'h10, 1'b1));
    check("t1_ready_low", {31'h0, monitor_ready}, 32'h0);
    check("t1_addr_loaded", {24'h0, MonAReg}, 32'h10);
    tick();
    tick();
    check("t1_ready_still_low", {31'h0, monitor_ready}, 32'h0);
    tick();
    check("t1_MonDReg", MonDReg, 32'hDEADBEEF);
    check("t1_MonAReg", {24'h0, MonAReg}, 32'h11);
    check("t1_ready", {31'h0, monitor_ready}, 32'h1);

    // Address-only load, then three writes wrapping through 0xFF
    jtag_strobe(0, jdo_addr(8'hFE, 1'b0));
    check("t2_load_ready", {31'h0, monitor_ready}, 32'h1);
    check("t2_load_addr", {24'h0, MonAReg}, 32'hFE);
    for (int k = 0; k < 3; k++) begin
      jtag_strobe(1, jdo_data(32'hA + 32'(k)));
      tick();
      tick();
      tick();
    end
    check("t2_MonAReg_wrap", {24'h0, MonAReg}, 32'h01);
    check("t2_mem_FE", mem[8'hFE], 32'hA);
    check("t2_mem_FF", mem[8'hFF], 32'hB);
    check("t2_mem_00", mem[8'h00], 32'hC);

    // Avalon read 0x20: waitrequest high 3 cycles, low on the 4th
    avs_xfer(1'b0, 8'h20, 32'h0, 4'hF, rd, waits);
    check("t3_waits", 32'(waits), 32'd3);
    check("t3_readdata", rd, 32'h12345678);

    // Table-driven transactions
    tbl[0] = '{1'b0, 1'b1, 8'h40, 32'h11223344, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 8'h40, 32'h0,        4'hF, 32'h11223344};
    tbl[2] = '{1'b0, 1'b1, 8'h40, 32'hAABBCCDD, 4'h5, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 8'h40, 32'h0,        4'hF, 32'h11BB33DD};
    tbl[4] = '{1'b1, 1'b1, 8'h41, 32'hCAFEF00D, 4'hF, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 8'h41, 32'h0,        4'hF, 32'hCAFEF00D};
    tbl[6] = '{1'b0, 1'b1, 8'h42, 32'h0BADF00D, 4'hF, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 8'h42, 32'h0,        4'hF, 32'h0BADF00D};
    tbl[8] = '{1'b1, 1'b0, 8'hFF, 32'h0,        4'hF, 32'h0000000B};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 32'h0,        4'hF, 32'h0000000C};
    for (int v = 0; v < 10; v++) begin
      nxt = tbl[v].addr + 8'd1;
      if (!tbl[v].jtag) begin
        avs_xfer(tbl[v].wr, tbl[v].addr, tbl[v].data, tbl[v].be, rd, waits);
        check($sformatf("vec%0d_waits", v), 32'(waits), tbl[v].wr ? 32'd2 : 32'd3);
        if (!tbl[v].wr) check($sformatf("vec%0d_readdata", v), rd, tbl[v].exp);
      end else if (tbl[v].wr) begin
        jtag_strobe(0, jdo_addr(tbl[v].addr, 1'b0));
        jtag_strobe(1, jdo_data(tbl[v].data));
        wait_ready($sformatf("vec%0d_ready", v));
        check($sformatf("vec%0d_MonAReg", v), {24'h0, MonAReg}, {24'h0, nxt});
      end else begin
        jtag_strobe(0, jdo_addr(tbl[v].addr, 1'b1));
        wait_ready($sformatf("vec%0d_ready", v));
        check($sformatf("vec%0d_MonDReg", v), MonDReg, tbl[v].exp);
        check($sformatf("vec%0d_MonAReg", v), {24'h0, MonAReg}, {24'h0, nxt});
      end
    end

    // Continuous Avalon reads with JTAG reads interleaved
    avs_address = 8'h20;
    avs_read = 1'b1;
    acks = 0; jdone = 0; jacc = 0; run = 0; max_run = 0; bad = 0;
    prev_ready = monitor_ready;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (!avs_waitrequest) begin
        acks++;
        run = 0;
        if (avs_readdata !== 32'h12345678) bad++;
      end
      if (monitor_ready && !prev_ready) begin
        jdone++;
        run++;
        if (run > max_run) max_run = run;
      end
      prev_ready = monitor_ready;
      take_no_action_ocimem_a = ((cyc % 4) == 0) && monitor_ready;
      if (take_no_action_ocimem_a) jacc++;
      tick();
    end
    take_no_action_ocimem_a = 1'b0;
    avs_read = 1'b0;
    wait_ready("t4_drain_ready");
    if (!prev_ready) jdone++;
    tick(); tick(); tick(); tick();
    check("t4_avs_acks_min5", {31'h0, acks >= 5}, 32'h1);
    check("t4_jtag_all_done", 32'(jdone), 32'(jacc));
    check("t4_jtag_ops_min4", {31'h0, jacc >= 4}, 32'h1);
    check("t4_max_jtag_between_acks", 32'(max_run), 32'd1);
    check("t4_avs_data_errors", 32'(bad), 32'd0);
    check("t4_no_overrun", {31'h0, jtag_overrun}, 32'h0);

    // Avalon read dropped after one cycle still completes and captures data
    avs_address = 8'h10;
    avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    tick();
    tick();
    check("drop_readdata", avs_readdata, 32'hDEADBEEF);
    tick();
    tick();

    // Overrun: second write strobe one cycle later is dropped
    jtag_strobe(0, jdo_addr(8'h50, 1'b0));
    jtag_strobe(1, jdo_data(32'h111));
    jtag_strobe(1, jdo_data(32'h222));
    wait_ready("t5_ready");
    tick();
    check("t5_overrun_set", {31'h0, jtag_overrun}, 32'h1);
    check("t5_mem_50", mem[8'h50], 32'h111);
    check("t5_mem_51", mem[8'h51], 32'h51);
    check("t5_MonAReg", {24'h0, MonAReg}, 32'h51);
    jtag_strobe(0, jdo_addr(8'h60, 1'b0));
    check("t5_overrun_cleared", {31'h0, jtag_overrun}, 32'h0);
    // Same-cycle a and b: a wins, b dropped, set beats clear
    jdo = jdo_addr(8'h70, 1'b0);
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    check("t5_same_cycle_addr", {24'h0, MonAReg}, 32'h70);
    check("t5_same_cycle_overrun", {31'h0, jtag_overrun}, 32'h1);
    check("t5_same_cycle_ready", {31'h0, monitor_ready}, 32'h1);
    jtag_strobe(0, jdo_addr(8'h70, 1'b0));
    check("t5_overrun_cleared2", {31'h0, jtag_overrun}, 32'h0);

    // Avalon write with and without debug mode
    debugack = 1'b0;
    avs_xfer(1'b1, 8'h30, 32'h55, 4'hF, rd, waits);
    check("t6_nodebug_waits", 32'(waits), 32'd2);
    tick();
`ifdef OCIMEM_WRITE_PROTECT_EN
    check("t6_nodebug_mem", mem[8'h30], 32'h30);
`else
    check("t6_nodebug_mem", mem[8'h30], 32'h55);
`endif
    debugack = 1'b1;
    avs_xfer(1'b1, 8'h30, 32'h55, 4'hF, rd, waits);
    check("t6_debug_waits", 32'(waits), 32'd2);
    tick();
    check("t6_debug_mem", mem[8'h30], 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
